// File: rtl/palette_bank_ram_if.sv
// rtl/palette_bank_ram_if.sv - pixel lookup and palette write bus for palette_bank_ram
interface palette_bank_ram_if #(
  parameter int INDEX_W   = 4,
  parameter int CH_W      = 4,
  parameter int NUM_BANKS = 4
);
  localparam int BANK_W = $clog2(NUM_BANKS);

  logic                 pix_valid;
  logic [INDEX_W-1:0]   pix_index;
  logic                 wr_en;
  logic [BANK_W-1:0]    wr_bank;
  logic [INDEX_W-1:0]   wr_addr;
  logic [3*CH_W-1:0]    wr_data;
  logic [CH_W-1:0]      red;
  logic [CH_W-1:0]      green;
  logic [CH_W-1:0]      blue;
  logic                 out_valid;
  logic                 transparent;

  modport master (
    output pix_valid, pix_index, wr_en, wr_bank, wr_addr, wr_data,
    input  red, green, blue, out_valid, transparent
  );

  modport slave (
    input  pix_valid, pix_index, wr_en, wr_bank, wr_addr, wr_data,
    output red, green, blue, out_valid, transparent
  );
endinterface

// File: rtl/palette_bank_ram.sv
// rtl/palette_bank_ram.sv - banked RGB palette lookup with frame-synchronous bank switch and colour cycling
// PALETTE_FADE_EN adds a frame-latched fade_level multiplier stage (lookup latency 2).
module palette_bank_ram #(
  parameter int INDEX_W   = 4,
  parameter int CH_W      = 4,
  parameter int NUM_BANKS = 4,
  parameter int CYC_PER_W = 6
) (
  input  logic                         Clk,
  input  logic                         Reset_n,
  palette_bank_ram_if.slave            bus,
  input  logic                         frame_start,
  input  logic [$clog2(NUM_BANKS)-1:0] bank_req,
  input  logic                         cyc_en,
  input  logic [INDEX_W-1:0]           cyc_lo,
  input  logic [INDEX_W-1:0]           cyc_hi,
  input  logic [CYC_PER_W-1:0]         cyc_period,
`ifdef PALETTE_FADE_EN
  input  logic [CH_W-1:0]              fade_level,
`endif
  output logic [$clog2(NUM_BANKS)-1:0] active_bank
);
  localparam int BANK_W = $clog2(NUM_BANKS);
  localparam int DEPTH  = 2**INDEX_W;
  localparam int RGB_W  = 3*CH_W;
  localparam int LEN_W  = INDEX_W + 1;

  logic [RGB_W-1:0]     ram [NUM_BANKS*DEPTH];

  logic [BANK_W-1:0]    bank_q, bank_d;
  logic                 cyc_en_q, cyc_en_d;
  logic [INDEX_W-1:0]   cyc_lo_q, cyc_lo_d;
  logic [INDEX_W-1:0]   cyc_hi_q, cyc_hi_d;
  logic [CYC_PER_W-1:0] cyc_period_q, cyc_period_d;
  logic [CYC_PER_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [INDEX_W-1:0]   offset_q, offset_d;
  logic                 valid_q, valid_d;
  logic                 transp_q, transp_d;
  logic [RGB_W-1:0]     rgb_q, rgb_d;

  logic                 cyc_active;
  logic                 in_range;
  logic                 new_active;
  logic [LEN_W-1:0]     cyc_len;
  logic [LEN_W-1:0]     rel;
  logic [LEN_W-1:0]     ofs_inc;
  logic [INDEX_W-1:0]   eff_index;

  // Contents are deliberately not reset; reading the pre-edge array gives read-before-write.
  always_ff @(posedge Clk) begin
    if (bus.wr_en) begin
      ram[{bus.wr_bank, bus.wr_addr}] <= bus.wr_data;
    end
  end

  always_comb begin
    cyc_active = cyc_en_q && (cyc_hi_q >= cyc_lo_q) && (cyc_period_q != '0);
    cyc_len    = {1'b0, cyc_hi_q} - {1'b0, cyc_lo_q} + LEN_W'(1);
    in_range   = cyc_active && (bus.pix_index >= cyc_lo_q) && (bus.pix_index <= cyc_hi_q);
    // Both terms are below cyc_len, so one conditional subtract wraps the sum.
    rel        = {1'b0, bus.pix_index - cyc_lo_q} + {1'b0, offset_q};
    if (rel >= cyc_len) begin
      rel = rel - cyc_len;
    end
    eff_index  = in_range ? (cyc_lo_q + rel[INDEX_W-1:0]) : bus.pix_index;
  end

  always_comb begin
    valid_d  = bus.pix_valid;
    transp_d = transp_q;
    rgb_d    = rgb_q;
    if (bus.pix_valid) begin
      transp_d = (bus.pix_index == '0);
      rgb_d    = ram[{bank_q, eff_index}];
    end
  end

  always_comb begin
    bank_d       = bank_q;
    cyc_en_d     = cyc_en_q;
    cyc_lo_d     = cyc_lo_q;
    cyc_hi_d     = cyc_hi_q;
    cyc_period_d = cyc_period_q;
    frame_cnt_d  = frame_cnt_q;
    offset_d     = offset_q;
    new_active   = cyc_en && (cyc_hi >= cyc_lo) && (cyc_period != '0);
    ofs_inc      = {1'b0, offset_q} + LEN_W'(1);
    if (frame_start) begin
      bank_d       = bank_req;
      cyc_en_d     = cyc_en;
      cyc_lo_d     = cyc_lo;
      cyc_hi_d     = cyc_hi;
      cyc_period_d = cyc_period;
      if (!new_active || (cyc_lo != cyc_lo_q) || (cyc_hi != cyc_hi_q)) begin
        frame_cnt_d = '0;
        offset_d    = '0;
      end else if (frame_cnt_q == cyc_period - CYC_PER_W'(1)) begin
        frame_cnt_d = '0;
        offset_d    = (ofs_inc == cyc_len) ? '0 : ofs_inc[INDEX_W-1:0];
      end else begin
        frame_cnt_d = frame_cnt_q + CYC_PER_W'(1);
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      bank_q       <= '0;
      cyc_en_q     <= 1'b0;
      cyc_lo_q     <= '0;
      cyc_hi_q     <= '0;
      cyc_period_q <= '0;
      frame_cnt_q  <= '0;
      offset_q     <= '0;
      valid_q      <= 1'b0;
      transp_q     <= 1'b0;
      rgb_q        <= '0;
    end else begin
      bank_q       <= bank_d;
      cyc_en_q     <= cyc_en_d;
      cyc_lo_q     <= cyc_lo_d;
      cyc_hi_q     <= cyc_hi_d;
      cyc_period_q <= cyc_period_d;
      frame_cnt_q  <= frame_cnt_d;
      offset_q     <= offset_d;
      valid_q      <= valid_d;
      transp_q     <= transp_d;
      rgb_q        <= rgb_d;
    end
  end

  assign active_bank = bank_q;

`ifdef PALETTE_FADE_EN
  logic [CH_W-1:0]  fade_q, fade_d;
  logic             valid2_q, valid2_d;
  logic             transp2_q, transp2_d;
  logic [RGB_W-1:0] rgb2_q, rgb2_d;

  always_comb begin
    fade_d    = frame_start ? fade_level : fade_q;
    valid2_d  = valid_q;
    transp2_d = transp2_q;
    rgb2_d    = rgb2_q;
    if (valid_q) begin
      transp2_d = transp_q;
      for (int c = 0; c < 3; c++) begin
        rgb2_d[c*CH_W +: CH_W] = CH_W'(({{CH_W{1'b0}}, rgb_q[c*CH_W +: CH_W]} *
                                         {{CH_W{1'b0}}, fade_q}) >> CH_W);
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fade_q    <= '0;
      valid2_q  <= 1'b0;
      transp2_q <= 1'b0;
      rgb2_q    <= '0;
    end else begin
      fade_q    <= fade_d;
      valid2_q  <= valid2_d;
      transp2_q <= transp2_d;
      rgb2_q    <= rgb2_d;
    end
  end

  assign bus.red         = rgb2_q[RGB_W-1 -: CH_W];
  assign bus.green       = rgb2_q[2*CH_W-1 -: CH_W];
  assign bus.blue        = rgb2_q[CH_W-1:0];
  assign bus.out_valid   = valid2_q;
  assign bus.transparent = transp2_q;
`else
  assign bus.red         = rgb_q[RGB_W-1 -: CH_W];
  assign bus.green       = rgb_q[2*CH_W-1 -: CH_W];
  assign bus.blue        = rgb_q[CH_W-1:0];
  assign bus.out_valid   = valid_q;
  assign bus.transparent = transp_q;
`endif
endmodule

// File: tb/tb_palette_bank_ram.sv
// tb/tb_palette_bank_ram.sv - table-driven self-checking bench for palette_bank_ram
module tb_palette_bank_ram;
`ifdef PALETTE_FADE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    bit          wr;
    logic [1:0]  wb;
    logic [3:0]  wa;
    logic [11:0] wd;
    bit          fs;
    logic [1:0]  breq;
    bit          cen;
    logic [3:0]  clo;
    logic [3:0]  chi;
    logic [5:0]  cper;
    logic [3:0]  idx;
    logic [11:0] exp_rgb;
    bit          exp_tr;
    logic [1:0]  exp_bank;
  } vec_t;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        frame_start;
  logic [1:0]  bank_req;
  logic        cyc_en;
  logic [3:0]  cyc_lo;
  logic [3:0]  cyc_hi;
  logic [5:0]  cyc_period;
  logic [1:0]  active_bank;
`ifdef PALETTE_FADE_EN
  logic [3:0]  fade_level;
  int          fade_model;
`endif

  int checks   = 0;
  int failures = 0;
  vec_t vecs[$];

  always #5 Clk = ~Clk;

  palette_bank_ram_if #(.INDEX_W(4), .CH_W(4), .NUM_BANKS(4)) bus ();

  palette_bank_ram #(.INDEX_W(4), .CH_W(4), .NUM_BANKS(4), .CYC_PER_W(6)) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .bus         (bus),
    .frame_start (frame_start),
    .bank_req    (bank_req),
    .cyc_en      (cyc_en),
    .cyc_lo      (cyc_lo),
    .cyc_hi      (cyc_hi),
    .cyc_period  (cyc_period),
`ifdef PALETTE_FADE_EN
    .fade_level  (fade_level),
`endif
    .active_bank (active_bank)
  );

  function automatic logic [11:0] expc(input logic [11:0] e);
`ifdef PALETTE_FADE_EN
    logic [11:0] r;
    for (int c = 0; c < 3; c++) begin
      r[c*4 +: 4] = 4'((int'(e[c*4 +: 4]) * fade_model) >> 4);
    end
    return r;
`else
    return e;
`endif
  endfunction

  function automatic vec_t mkv(bit wr, logic [1:0] wb, logic [3:0] wa, logic [11:0] wd,
                               bit fs, logic [1:0] breq, bit cen, logic [3:0] clo,
                               logic [3:0] chi, logic [5:0] cper, logic [3:0] idx,
                               logic [11:0] exp_rgb, bit exp_tr, logic [1:0] exp_bank);
    vec_t r;
    r.wr = wr; r.wb = wb; r.wa = wa; r.wd = wd;
    r.fs = fs; r.breq = breq; r.cen = cen; r.clo = clo; r.chi = chi; r.cper = cper;
    r.idx = idx; r.exp_rgb = exp_rgb; r.exp_tr = exp_tr; r.exp_bank = exp_bank;
    return r;
  endfunction

  task automatic tick();
    @(negedge Clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic do_write(input logic [1:0] b, input logic [3:0] a, input logic [11:0] d);
    bus.wr_en = 1'b1; bus.wr_bank = b; bus.wr_addr = a; bus.wr_data = d;
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic do_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
`ifdef PALETTE_FADE_EN
    fade_model = int'(fade_level);
`endif
  endtask

  task automatic lookup(input logic [3:0] idx, output logic [11:0] rgb, output logic v, output logic t);
    bus.pix_valid = 1'b1; bus.pix_index = idx;
    tick();
    bus.pix_valid = 1'b0;
    repeat (LAT-1) tick();
    rgb = {bus.red, bus.green, bus.blue};
    v   = bus.out_valid;
    t   = bus.transparent;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] rgb;
    logic        v;
    logic        t;

    //            wr wb wa  wd      fs br cen lo hi per idx exp     tr bank
    vecs.push_back(mkv(1, 0, 5, 12'hA09, 0, 0, 0, 0, 0, 0, 5, 12'hA09, 0, 0));
    vecs.push_back(mkv(1, 0, 0, 12'h555, 0, 0, 0, 0, 0, 0, 0, 12'h555, 1, 0));
    vecs.push_back(mkv(1, 0, 3, 12'h333, 0, 0, 0, 0, 0, 0, 3, 12'h333, 0, 0));
    vecs.push_back(mkv(1, 2, 3, 12'h123, 0, 2, 0, 0, 0, 0, 3, 12'h333, 0, 0));
    vecs.push_back(mkv(0, 0, 0, 12'h000, 1, 2, 0, 0, 0, 0, 3, 12'h123, 0, 2));
    vecs.push_back(mkv(0, 0, 0, 12'h000, 1, 0, 0, 0, 0, 0, 5, 12'hA09, 0, 0));
    vecs.push_back(mkv(1, 0, 8, 12'h100, 0, 0, 0, 0, 0, 0, 8, 12'h100, 0, 0));
    vecs.push_back(mkv(1, 0, 9, 12'h200, 0, 0, 0, 0, 0, 0, 9, 12'h200, 0, 0));
    vecs.push_back(mkv(1, 0, 10, 12'h300, 0, 0, 0, 0, 0, 0, 10, 12'h300, 0, 0));
    vecs.push_back(mkv(1, 0, 11, 12'h400, 0, 0, 0, 0, 0, 0, 11, 12'h400, 0, 0));
    vecs.push_back(mkv(1, 0, 12, 12'hC0C, 0, 0, 0, 0, 0, 0, 12, 12'hC0C, 0, 0));
    vecs.push_back(mkv(0, 0, 0, 12'h000, 1, 0, 1, 8, 11, 2, 8, 12'h100, 0, 0));
    vecs.push_back(mkv(0, 0, 0, 12'h000, 0, 0, 1, 8, 11, 2, 9, 12'h200, 0, 0));
    vecs.push_back(mkv(0, 0, 0, 12'h000, 1, 0, 1, 8, 11, 2, 8, 12'h100, 0, 0));
    vecs.push_back(mkv(0, 0, 0, 12'h000, 1, 0, 1, 8, 11, 2, 8, 12'h200, 0, 0));
    vecs.push_back(mkv(0, 0, 0, 12'h000, 0, 0, 1, 8, 11, 2, 11, 12'h100, 0, 0));
    vecs.push_back(mkv(0, 0, 0, 12'h000, 0, 0, 1, 8, 11, 2, 12, 12'hC0C, 0, 0));
    vecs.push_back(mkv(0, 0, 0, 12'h000, 1, 0, 1, 8, 11, 2, 8, 12'h200, 0, 0));
    vecs.push_back(mkv(0, 0, 0, 12'h000, 1, 0, 1, 8, 11, 2, 8, 12'h300, 0, 0));
    vecs.push_back(mkv(0, 0, 0, 12'h000, 1, 0, 1, 8, 11, 2, 8, 12'h300, 0, 0));
    vecs.push_back(mkv(0, 0, 0, 12'h000, 1, 0, 1, 8, 11, 2, 8, 12'h400, 0, 0));
    vecs.push_back(mkv(0, 0, 0, 12'h000, 1, 0, 1, 8, 11, 2, 8, 12'h400, 0, 0));
    vecs.push_back(mkv(0, 0, 0, 12'h000, 1, 0, 1, 8, 11, 2, 8, 12'h100, 0, 0));
    vecs.push_back(mkv(0, 0, 0, 12'h000, 1, 0, 1, 8, 11, 2, 8, 12'h100, 0, 0));
    vecs.push_back(mkv(0, 0, 0, 12'h000, 1, 0, 1, 8, 11, 2, 8, 12'h200, 0, 0));
    vecs.push_back(mkv(0, 0, 0, 12'h000, 1, 0, 1, 5, 3, 2, 8, 12'h100, 0, 0));
    vecs.push_back(mkv(0, 0, 0, 12'h000, 1, 0, 1, 8, 11, 2, 8, 12'h100, 0, 0));
    vecs.push_back(mkv(0, 0, 0, 12'h000, 1, 0, 1, 8, 11, 2, 8, 12'h100, 0, 0));
    vecs.push_back(mkv(0, 0, 0, 12'h000, 1, 0, 1, 8, 11, 2, 8, 12'h200, 0, 0));
    vecs.push_back(mkv(0, 0, 0, 12'h000, 1, 0, 1, 8, 11, 0, 8, 12'h100, 0, 0));
    vecs.push_back(mkv(0, 0, 0, 12'h000, 1, 0, 1, 8, 11, 2, 8, 12'h100, 0, 0));
    vecs.push_back(mkv(0, 0, 0, 12'h000, 1, 0, 1, 8, 11, 2, 8, 12'h200, 0, 0));
    vecs.push_back(mkv(0, 0, 0, 12'h000, 1, 0, 0, 8, 11, 2, 8, 12'h100, 0, 0));
    vecs.push_back(mkv(1, 0, 1, 12'h0A1, 1, 0, 1, 0, 1, 1, 0, 12'h555, 1, 0));
    vecs.push_back(mkv(0, 0, 0, 12'h000, 1, 0, 1, 0, 1, 1, 0, 12'h0A1, 1, 0));
    vecs.push_back(mkv(0, 0, 0, 12'h000, 1, 0, 0, 0, 1, 1, 0, 12'h555, 1, 0));

    Reset_n = 1'b0; frame_start = 1'b0; bank_req = '0;
    cyc_en = 1'b0; cyc_lo = '0; cyc_hi = '0; cyc_period = '0;
    bus.pix_valid = 1'b0; bus.pix_index = '0;
    bus.wr_en = 1'b0; bus.wr_bank = '0; bus.wr_addr = '0; bus.wr_data = '0;
`ifdef PALETTE_FADE_EN
    fade_level = 4'hF; fade_model = 0;
`endif
    tick(); tick();
    check("reset_rgb", {bus.red, bus.green, bus.blue}, 12'h000);
    check("reset_valid", bus.out_valid, 1'b0);
    check("reset_transp", bus.transparent, 1'b0);
    check("reset_bank", active_bank, 2'd0);
    Reset_n = 1'b1;
    tick();

    foreach (vecs[i]) begin
      bank_req = vecs[i].breq;
      if (vecs[i].wr) do_write(vecs[i].wb, vecs[i].wa, vecs[i].wd);
      if (vecs[i].fs) begin
        cyc_en = vecs[i].cen; cyc_lo = vecs[i].clo; cyc_hi = vecs[i].chi; cyc_period = vecs[i].cper;
        do_frame();
      end
      lookup(vecs[i].idx, rgb, v, t);
      check($sformatf("v%0d_rgb", i), rgb, expc(vecs[i].exp_rgb));
      check($sformatf("v%0d_valid", i), v, 1'b1);
      check($sformatf("v%0d_transp", i), t, vecs[i].exp_tr);
      check($sformatf("v%0d_bank", i), active_bank, vecs[i].exp_bank);
    end

    // Same-cycle write and lookup of one entry returns the old data.
    do_write(0, 7, 12'h000);
    bus.wr_en = 1'b1; bus.wr_bank = 0; bus.wr_addr = 7; bus.wr_data = 12'hFFF;
    bus.pix_valid = 1'b1; bus.pix_index = 7;
    tick();
    bus.wr_en = 1'b0; bus.pix_valid = 1'b0;
    repeat (LAT-1) tick();
    check("rbw_old", {bus.red, bus.green, bus.blue}, expc(12'h000));
    lookup(7, rgb, v, t);
    check("rbw_new", rgb, expc(12'hFFF));

    // Lookup coinciding with frame_start uses the pre-switch bank.
    do_write(1, 5, 12'h0B1);
    frame_start = 1'b1; bank_req = 1; bus.pix_valid = 1'b1; bus.pix_index = 5;
    tick();
    frame_start = 1'b0; bus.pix_valid = 1'b0;
`ifdef PALETTE_FADE_EN
    fade_model = int'(fade_level);
`endif
    repeat (LAT-1) tick();
    check("fs_pix_rgb", {bus.red, bus.green, bus.blue}, expc(12'hA09));
    check("fs_pix_bank", active_bank, 2'd1);
    lookup(5, rgb, v, t);
    check("bank1_rgb", rgb, expc(12'h0B1));
    tick();
    check("hold_valid", bus.out_valid, 1'b0);
    check("hold_rgb", {bus.red, bus.green, bus.blue}, expc(12'h0B1));

    // Asynchronous reset mid-stream.
    bus.pix_valid = 1'b1; bus.pix_index = 5;
    #2 Reset_n = 1'b0;
    #1;
    check("arst_rgb", {bus.red, bus.green, bus.blue}, 12'h000);
    check("arst_valid", bus.out_valid, 1'b0);
    check("arst_transp", bus.transparent, 1'b0);
    check("arst_bank", active_bank, 2'd0);
    tick();
    bus.pix_valid = 1'b0; bank_req = 0; Reset_n = 1'b1;
`ifdef PALETTE_FADE_EN
    fade_model = 0;
`endif
    tick();
    check("post_rst_valid", bus.out_valid, 1'b0);
    lookup(5, rgb, v, t);
    check("ram_persist_rgb", rgb, expc(12'hA09));
    check("ram_persist_valid", v, 1'b1);

`ifdef PALETTE_FADE_EN
    fade_level = 4'd8;
    do_frame();
    do_write(0, 6, 12'hF84);
    lookup(6, rgb, v, t);
    check("fade8_rgb", rgb, 12'h742);
    fade_level = 4'd0;
    do_frame();
    lookup(6, rgb, v, t);
    check("fade0_rgb", rgb, 12'h000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/palette_bank_ram.md
Name: palette_bank_ram

Overview:
- Writable, multi-bank sprite/background palette. Replaces fixed per-sprite ROM palettes.
- Maps a pixel colour index to 12-bit RGB through a registered lookup, with frame-synchronous bank switching and colour-cycling animation.
- Sits between the sprite/tile pixel fetch and the VGA colour mux.
- Written by the loader/CPU over a simple write port.

Parameters:
- INDEX_W, 4, colour index width; each bank has 2**INDEX_W entries.
- CH_W, 4, bits per colour channel; stored entry is 3*CH_W bits, {R,G,B}.
- NUM_BANKS, 4, number of palette banks (power of 2, >=2).
- CYC_PER_W, 6, width of the colour-cycle frame-period register.

Ports:
- Clk  in  1  system clock
- Reset_n  in  1  asynchronous active-low reset
- frame_start  in  1  one-cycle pulse at start of vertical blank
- bank_req  in  $clog2(NUM_BANKS)  requested display bank, sampled on frame_start
- pix_valid  in  1  pix_index valid this cycle
- pix_index  in  INDEX_W  colour index from pixel fetch
- wr_en  in  1  palette write strobe
- wr_bank  in  $clog2(NUM_BANKS)  write bank
- wr_addr  in  INDEX_W  write entry
- wr_data  in  3*CH_W  {R,G,B} write data
- cyc_en  in  1  colour cycling enable, sampled on frame_start
- cyc_lo  in  INDEX_W  first index of cycling range, sampled on frame_start
- cyc_hi  in  INDEX_W  last index of cycling range, sampled on frame_start
- cyc_period  in  CYC_PER_W  frames per cycle step, sampled on frame_start
- red, green, blue  out  CH_W each  looked-up colour
- out_valid  out  1  colour outputs valid
- transparent  out  1  original index was 0 (colour key)
- active_bank  out  $clog2(NUM_BANKS)  bank currently displayed

Behaviour:
- Reset, asynchronous on Reset_n low, all to 0:
  - red/green/blue, out_valid, transparent, active_bank.
  - Latched cycle config and frame counter.
  - Cycle offset.
- RAM contents are not reset and persist across reset.
- Lookup pipeline, latency 1 (FADE_EN off):
  - pix_valid/pix_index at edge N produce out_valid/colour/transparent after edge N+1.
  - out_valid is pix_valid delayed by one cycle.
  - Colour outputs hold their last value when out_valid is 0.
- Effective index:
  - Applies when cycling is active and cyc_lo <= idx <= cyc_hi: eff = cyc_lo + ((idx - cyc_lo + offset) mod L), with L = cyc_hi - cyc_lo + 1.
  - offset is always < L, so the mod is a single conditional subtract.
  - Otherwise eff = idx.
- transparent is based on the raw pix_index == 0, even if index 0 lies inside the cycle range.
- Bank switching:
  - active_bank loads bank_req only on frame_start, so there is never a mid-frame switch.
  - Lookups use active_bank.
- Writes:
  - Any bank, any cycle, including the displayed bank.
  - On a same-cycle write and read of the same bank/entry, the read returns the old data (read-before-write). The new data is visible on the next lookup.
- Colour-cycle controller:
  - On frame_start: latch cyc_en/cyc_lo/cyc_hi/cyc_period.
  - If latched cyc_en=0, cyc_hi<cyc_lo, or cyc_period=0: cycling is inactive, offset=0 and frame counter=0.
  - Active, on each frame_start: if frame_cnt == period-1, then frame_cnt<=0 and offset<=(offset+1==L)?0:offset+1. Otherwise frame_cnt++.
  - If the latched lo/hi change value on a frame_start, offset and frame_cnt clear to 0.
  - Offset only changes on frame_start, so it is constant within a frame.
- Simultaneous frame_start and pix_valid: the lookup in that cycle uses the pre-update bank and offset. The new values apply from the next cycle.
- Reset mid-frame: the pipeline is flushed (out_valid=0) and the bank returns to 0.

Optional Feature:
- Macro: PALETTE_FADE_EN.
- Defined:
  - Adds input fade_level (CH_W bits), sampled on frame_start.
  - Each channel output = (chan * fade_level) >> CH_W, computed in an extra pipeline register. Max level 2**CH_W-1 gives near-full brightness; 0 gives black.
  - Latency becomes 2; out_valid and transparent are delayed to match.
  - Reset value of the latched fade level is 0 (black until the first frame_start).
- Not defined: no fade_level port, latency 1, colours unscaled.

Test Plan:
- Reset, write bank0 entry 5=0xA09, lookup index 5 -> one cycle later {red,green,blue}=A,0,9, out_valid=1, transparent=0; index 0 -> transparent=1.
- Write bank2 entry 3=0x123, bank_req=2 asserted mid-frame -> lookup still uses bank0 until frame_start, then active_bank=2 and index 3 gives 0x123.
- Same-cycle write entry 7=0xFFF and lookup 7 (old 0x000) -> output 0x000; next lookup 7 gives 0xFFF.
- cyc_en=1, lo=8, hi=11, period=2; entries 8..11 = 0x100,0x200,0x300,0x400 -> index 8 outputs 0x100 in frames 0-1, 0x200 in frames 2-3, and wraps back to 0x100 after frame 7; index 12 is unaffected.
- cyc_hi=3, cyc_lo=5 or period=0 -> cycling inactive, offset 0, identity mapping; assert Reset_n low mid-stream -> outputs, out_valid and active_bank go to 0 immediately.
- With PALETTE_FADE_EN, fade_level=8, entry=0xF84 -> output 0x742 after 2 cycles; fade_level=0 -> 0x000.
